// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - multi-cycle IEEE-754 single-precision adder (IDLE/ALIGN/ADD/NORM/ROUND/DONE)
// Define FPADD_ROUND_NEAREST_EN to keep guard/round/sticky bits and round to nearest even; default truncates.
module fp_add_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
  state_t r_state, w_next;

  logic [31:0] r_a, r_b, r_spec_val, r_result;
  logic        r_special, r_sign, r_sub, r_ovf, r_unf;
  logic [8:0]  r_exp;
  // r_mant layout: [27] carry, [26:3] mantissa with hidden bit, [2:0] guard/round/sticky
  logic [27:0] r_mant, r_mant_sm;

  logic [30:0] w_mag_a, w_mag_b;
  logic [31:0] w_big, w_sml;
  logic [23:0] w_mant_big, w_mant_sml;
  logic [7:0]  w_diff;
  logic [26:0] w_aligned;
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_special;
  logic [31:0] w_spec_val;
  logic        w_shift;
  logic [23:0] w_fin_mant;
  logic [8:0]  w_fin_exp;

  // Operands with a zero exponent are flushed to zero before the magnitude compare
  assign w_mag_a    = (r_a[30:23] == 8'd0) ? 31'd0 : r_a[30:0];
  assign w_mag_b    = (r_b[30:23] == 8'd0) ? 31'd0 : r_b[30:0];
  assign w_big      = (w_mag_a >= w_mag_b) ? {r_a[31], w_mag_a} : {r_b[31], w_mag_b};
  assign w_sml      = (w_mag_a >= w_mag_b) ? {r_b[31], w_mag_b} : {r_a[31], w_mag_a};
  assign w_mant_big = (w_big[30:23] == 8'd0) ? 24'd0 : {1'b1, w_big[22:0]};
  assign w_mant_sml = (w_sml[30:23] == 8'd0) ? 24'd0 : {1'b1, w_sml[22:0]};
  assign w_diff     = w_big[30:23] - w_sml[30:23];

`ifdef FPADD_ROUND_NEAREST_EN
  logic [26:0] w_ext, w_sh;
  logic        w_stk, w_up;
  logic [24:0] w_rnd;
  assign w_ext      = {w_mant_sml, 3'b000};
  assign w_sh       = w_ext >> w_diff;
  assign w_stk      = (w_sh << w_diff) != w_ext;
  assign w_aligned  = (w_diff >= 8'd26) ? 27'd0 : {w_sh[26:1], w_sh[0] | w_stk};
  assign w_up       = r_mant[2] & (r_mant[3] | r_mant[1] | r_mant[0]);
  assign w_rnd      = {1'b0, r_mant[26:3]} + {24'd0, w_up};
  assign w_fin_mant = w_rnd[24] ? w_rnd[24:1] : w_rnd[23:0];
  assign w_fin_exp  = r_exp + {8'd0, w_rnd[24]};
`else
  assign w_aligned  = (w_diff >= 8'd26) ? 27'd0 : {w_mant_sml >> w_diff, 3'b000};
  assign w_fin_mant = r_mant[26:3];
  assign w_fin_exp  = r_exp;
`endif

  assign w_nan_a    = (&r_a[30:23]) && (|r_a[22:0]);
  assign w_nan_b    = (&r_b[30:23]) && (|r_b[22:0]);
  assign w_inf_a    = (&r_a[30:23]) && !(|r_a[22:0]);
  assign w_inf_b    = (&r_b[30:23]) && !(|r_b[22:0]);
  assign w_special  = w_nan_a || w_nan_b || w_inf_a || w_inf_b;
  assign w_spec_val = (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (r_a[31] != r_b[31]))) ? 32'h7FC00000 :
                      w_inf_a ? r_a : r_b;

  assign w_shift = !r_mant[26] && (r_mant != 28'd0) && (r_exp > 9'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  if (r_special || r_mant[27] || !w_shift) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (r_state == S_IDLE);
    busy          = (r_state != S_IDLE);
    out_valid     = (r_state == S_DONE);
    out_result    = r_result;
    out_overflow  = r_ovf;
    out_underflow = r_unf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= 32'd0; r_b <= 32'd0; r_spec_val <= 32'd0; r_result <= 32'd0;
      r_special <= 1'b0; r_sign <= 1'b0; r_sub <= 1'b0; r_ovf <= 1'b0; r_unf <= 1'b0;
      r_exp <= 9'd0; r_mant <= 28'd0; r_mant_sm <= 28'd0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= in_a;
          r_b <= in_b;
        end
        S_ALIGN: begin
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
          r_sign     <= w_big[31];
          r_sub      <= w_big[31] ^ w_sml[31];
          r_exp      <= {1'b0, w_big[30:23]};
          r_mant     <= {1'b0, w_mant_big, 3'b000};
          r_mant_sm  <= {1'b0, w_aligned};
        end
        S_ADD: r_mant <= r_sub ? (r_mant - r_mant_sm) : (r_mant + r_mant_sm);
        S_NORM: if (!r_special) begin
          if (r_mant[27]) begin
            r_mant <= {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
            r_exp  <= r_exp + 9'd1;
          end else if (w_shift) begin
            r_mant <= {r_mant[26:0], 1'b0};
            r_exp  <= r_exp - 9'd1;
          end
        end
        S_ROUND: begin
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
          if (r_special)              r_result <= r_spec_val;
          else if (r_mant == 28'd0)   r_result <= 32'd0;
          else if (!r_mant[26]) begin
            // Normalising would need exponent 0: flush to signed zero
            r_result <= {r_sign, 31'd0};
            r_unf    <= 1'b1;
          end else if (w_fin_exp >= 9'd255) begin
            r_result <= {r_sign, 8'hFF, 23'd0};
            r_ovf    <= 1'b1;
          end else    r_result <= {r_sign, w_fin_exp[7:0], w_fin_mant[22:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb/tb_fp_add_sequencer.sv - randomized self-checking bench for fp_add_sequencer against an integer reference model
module tb_fp_add_sequencer;
  logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_a = 32'd0, in_b = 32'd0;
  logic        in_ready, out_valid, out_overflow, out_underflow, busy;
  logic [31:0] out_result;
  logic [31:0] cur_a, cur_b;
  int          n_checks = 0, n_errors = 0;

  fp_add_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_underflow(out_underflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s a=%h b=%h got=%h exp=%h", tag, cur_a, cur_b, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: values as scaled integers (mantissa << 3), rules applied with plain arithmetic
  function automatic void ref_add(input logic [31:0] a_in, input logic [31:0] b_in,
                                  output logic [31:0] r, output logic ov, output logic un, output int k);
    logic [31:0] a, b, t;
    longint ma, mb, s, m, lost;
    int ea, eb, e, d;
    bit nan_a, nan_b, inf_a, inf_b;
    a = a_in; b = b_in; r = 32'd0; ov = 1'b0; un = 1'b0; k = 0;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (nan_a || nan_b || (inf_a && inf_b && a[31] != b[31])) begin r = 32'h7FC00000; return; end
    if (inf_a) begin r = a; return; end
    if (inf_b) begin r = b; return; end
    if (a[30:23] == 8'd0) a = {a[31], 31'd0};
    if (b[30:23] == 8'd0) b = {b[31], 31'd0};
    if (b[30:0] > a[30:0]) begin t = a; a = b; b = t; end
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 0 : (longint'(a[22:0]) + (longint'(1) << 23));
    mb = (eb == 0) ? 0 : (longint'(b[22:0]) + (longint'(1) << 23));
    ma = ma << 3;
    mb = mb << 3;
    d = ea - eb;
    if (d >= 26) mb = 0;
    else begin
`ifdef FPADD_ROUND_NEAREST_EN
      lost = mb & ((longint'(1) << d) - 1);
      mb = (mb >> d) | ((lost != 0) ? 1 : 0);
`else
      lost = 0;
      mb = ((mb >> 3) >> d) << 3;
`endif
    end
    s = (a[31] == b[31]) ? ma + mb : ma - mb;
    if (s == 0) return;
    e = ea;
    if (s >= (longint'(1) << 27)) begin s = (s >> 1) | (s & 1); e++; end
    else while (s < (longint'(1) << 26) && e > 1) begin s = s << 1; e--; k++; end
    if (s < (longint'(1) << 26)) begin r = {a[31], 31'd0}; un = 1'b1; return; end
    m = s >> 3;
`ifdef FPADD_ROUND_NEAREST_EN
    if (((s >> 2) & 1) == 1 && ((s & 3) != 0 || (m & 1) == 1)) m++;
    if (m == (longint'(1) << 24)) begin m = m >> 1; e++; end
`endif
    if (e >= 255) begin r = {a[31], 8'hFF, 23'd0}; ov = 1'b1; end
    else r = {a[31], 8'(e), 23'(m)};
  endfunction

  task automatic wait_result(input logic [31:0] er, input logic eo, input logic eu, input int elat);
    int n;
    n = 1;
    while (!out_valid && n < 60) begin tick; n++; end
    check("latency", n, elat);
    check("result", out_result, er);
    check("overflow", out_overflow, eo);
    check("underflow", out_underflow, eu);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input bit use_fixed,
                        input logic [31:0] fr, input logic fo, input logic fu, input int flat);
    logic [31:0] er, held;
    logic eo, eu;
    int ek, n;
    ref_add(a, b, er, eo, eu, ek);
    if (use_fixed) begin er = fr; eo = fo; eu = fu; ek = flat - 5; end
    cur_a = a; cur_b = b;
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick;
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    wait_result(er, eo, eu, 5 + ek);
    held = out_result;
    for (int i = 0; i < hold; i++) begin
      tick;
      check("hold_result", out_result, held);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("back_to_idle", in_ready, 1);
    check("valid_dropped", out_valid, 0);
  endtask

  function automatic logic [31:0] rnd_special();
    case ($urandom_range(0, 5))
      0: return 32'h7F800000;
      1: return 32'hFF800000;
      2: return 32'h7FC00000 | ($urandom & 32'h003FFFFF);
      3: return 32'hFF800001;
      4: return 32'h00000000;
      default: return 32'h80000000 | ($urandom & 32'h007FFFFF);
    endcase
  endfunction

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0: begin a = $urandom; b = $urandom; end
      1: begin
        a = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(90, 160)), 23'($urandom)};
      end
      2: begin
        a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        b = a ^ 32'h80000000 ^ ($urandom & 32'h000000FF);
      end
      3: begin
        a = rnd_special(); b = $urandom;
        if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
      end
      4: begin
        a = {1'($urandom), 8'($urandom_range(253, 254)), 23'($urandom)};
        b = {a[31], 8'($urandom_range(252, 254)), 23'($urandom)};
      end
      default: begin
        a = {1'($urandom), 8'($urandom_range(1, 4)), 23'($urandom)};
        b = a ^ 32'h80000000 ^ ($urandom & 32'h0003FFFF);
      end
    endcase
  endtask

  logic [31:0] da[8], db[8], dr[8];
  logic        dov[8], dun[8];
  int          dl[8];

  initial begin
    logic [31:0] a, b, er;
    logic eo, eu;
    int ek;
    cur_a = 32'd0; cur_b = 32'd0;
    da[0] = 32'h3F800000; db[0] = 32'h3F800000; dr[0] = 32'h40000000; dov[0] = 0; dun[0] = 0; dl[0] = 5;
    da[1] = 32'h3F800000; db[1] = 32'hBF400000; dr[1] = 32'h3E800000; dov[1] = 0; dun[1] = 0; dl[1] = 7;
    da[2] = 32'h7F800000; db[2] = 32'hFF800000; dr[2] = 32'h7FC00000; dov[2] = 0; dun[2] = 0; dl[2] = 5;
    da[3] = 32'h7F7FFFFF; db[3] = 32'h7F7FFFFF; dr[3] = 32'h7F800000; dov[3] = 1; dun[3] = 0; dl[3] = 5;
`ifdef FPADD_ROUND_NEAREST_EN
    da[4] = 32'h3F800000; db[4] = 32'h33C00000; dr[4] = 32'h3F800001; dov[4] = 0; dun[4] = 0; dl[4] = 5;
`else
    da[4] = 32'h3F800000; db[4] = 32'h33C00000; dr[4] = 32'h3F800000; dov[4] = 0; dun[4] = 0; dl[4] = 5;
`endif
    da[5] = 32'h01800000; db[5] = 32'h817FFFFF; dr[5] = 32'h00000000; dov[5] = 0; dun[5] = 1; dl[5] = 7;
    da[6] = 32'h40490FDB; db[6] = 32'hC0490FDB; dr[6] = 32'h00000000; dov[6] = 0; dun[6] = 0; dl[6] = 5;
    da[7] = 32'h00400000; db[7] = 32'h3F800000; dr[7] = 32'h3F800000; dov[7] = 0; dun[7] = 0; dl[7] = 5;

    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    tick; tick;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_op(da[i], db[i], (i == 0) ? 2 : 0, 1'b1, dr[i], dov[i], dun[i], dl[i]);

    // Backpressure in DONE with a second pair already waiting on the input
    cur_a = 32'h3F800000; cur_b = 32'h40000000;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
    tick;
    in_a = 32'h40400000; in_b = 32'hBF800000;
    wait_result(32'h40400000, 1'b0, 1'b0, 5);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("bp_result", out_result, 32'h40400000);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    tick;
    check("bp_second_accepted", busy, 1);
    in_valid = 1'b0;
    cur_a = 32'h40400000; cur_b = 32'hBF800000;
    wait_result(32'h40000000, 1'b0, 1'b0, 5);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Reset mid-normalisation discards the operation
    cur_a = 32'h3F800000; cur_b = 32'hBF7FFFFF;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'hBF7FFFFF;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    #2 reset = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_result", out_result, 32'd0);
    check("midrst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    tick;
    reset = 1'b1;
    run_op(32'h3F800000, 32'hBF400000, 0, 1'b1, 32'h3E800000, 1'b0, 1'b0, 7);

    for (int i = 0; i < 300; i++) begin
      gen_pair(a, b);
      run_op(a, b, $urandom_range(0, 1), 1'b0, 32'd0, 1'b0, 1'b0, 0);
    end
    ref_add(32'h3F800000, 32'h3F800000, er, eo, eu, ek);
    run_op(32'h3F800000, 32'h3F800000, 0, 1'b0, er, eo, eu, ek);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
